// File: rtl/regfile_wb_sched_if.sv
// Writeback-scheduler bus bundle.
//   Requesters present wb_valid/wb_rd/wb_data per lane and see a one-hot
//   wb_ready grant. rf_* is the registered register-file write port. iss_* is
//   the issue-stage hazard query. flush is the pipeline flush. busy is the
//   scoreboard view.
//   wb_rd[i] and wb_data[i] occupy bits [5i+4:5i] and [64i+63:64i] of the
//   packed vectors.
// master: execute/issue side, which drives requests. slave: the scheduler.
interface regfile_wb_sched_if #(parameter int N = 3);
  logic [N-1:0]        wb_valid;
  logic [N-1:0][4:0]   wb_rd;
  logic [N-1:0][63:0]  wb_data;
  logic [N-1:0]        wb_ready;
  logic                rf_wen;
  logic [4:0]          rf_rd;
  logic [63:0]         rf_wdata;
  logic                iss_valid;
  logic                iss_rd_en;
  logic [4:0]          iss_rd;
  logic [4:0]          iss_rs1;
  logic [4:0]          iss_rs2;
  logic                iss_ready;
  logic                flush;
  logic [31:0]         busy;

  modport master (
    output wb_valid, wb_rd, wb_data, iss_valid, iss_rd_en, iss_rd, iss_rs1,
           iss_rs2, flush,
    input  wb_ready, rf_wen, rf_rd, rf_wdata, iss_ready, busy
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, iss_valid, iss_rd_en, iss_rd, iss_rs1,
           iss_rs2, flush,
    output wb_ready, rf_wen, rf_rd, rf_wdata, iss_ready, busy
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and busy scoreboard for the 32 x 64-bit register file.
//   clock, reset : rising-edge clock and asynchronous active-high reset.
//   bus (slave)  : N writeback requesters that share one register-file write
//                  port through round-robin arbitration. The block also
//                  provides a RAW/WAW hazard check for the issue stage and the
//                  per-register busy bits.
module regfile_wb_sched #(
  parameter int N = 3
) (
  input  logic              clock,
  input  logic              reset,
  regfile_wb_sched_if.slave bus
);

  logic [2:0]   ptr, ptr_nxt;
  logic [N-1:0] grant;
  logic         gnt_any;
  logic [4:0]   sel_rd;
  logic [63:0]  sel_data;
  logic [31:0]  busy_q, busy_nxt;
  logic         issue;

  // Round-robin grant. The first pass covers indices ptr..N-1 and the second
  // pass wraps around to 0. This yields a mod-N scan without variable-width
  // index arithmetic.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && bus.wb_valid[i] && (3'(i) >= ptr)) begin
        grant[i] = 1'b1;
        gnt_any  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && bus.wb_valid[i]) begin
        grant[i] = 1'b1;
        gnt_any  = 1'b1;
      end
    end
    if (bus.flush) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign bus.wb_ready = grant;

  // The grant is one-hot, so an AND-OR mux selects the winning lane. The same
  // loop computes the pointer that follows the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    ptr_nxt  = ptr;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | bus.wb_rd[i];
        sel_data = sel_data | bus.wb_data[i];
        ptr_nxt  = (i == N - 1) ? 3'd0 : 3'(i + 1);
      end
    end
  end

  // Output stage. A handshake always completes, but a write to x0 is dropped
  // by holding rf_wen low. rf_rd and rf_wdata hold when no handshake occurs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      bus.rf_wen   <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (gnt_any) begin
        bus.rf_wen   <= (sel_rd != 5'd0);
        bus.rf_rd    <= sel_rd;
        bus.rf_wdata <= sel_data;
      end else begin
        bus.rf_wen   <= 1'b0;
      end
    end
  end

  // The hazard check uses only the scoreboard and the issue fields, so it has
  // no path from wb_valid. Register x0 never stalls.
  assign bus.iss_ready = ~bus.flush
                       & ~(busy_q[bus.iss_rs1] & (bus.iss_rs1 != 5'd0))
                       & ~(busy_q[bus.iss_rs2] & (bus.iss_rs2 != 5'd0))
                       & ~(bus.iss_rd_en & busy_q[bus.iss_rd] & (bus.iss_rd != 5'd0));

  assign issue = bus.iss_valid & bus.iss_ready & bus.iss_rd_en;

  // The clear is applied first so that a set to the same register wins. A
  // flush overrides both.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.rf_wen)
      busy_nxt[bus.rf_rd] = 1'b0;
    if (issue)
      busy_nxt[bus.iss_rd] = 1'b1;
    if (bus.flush)
      busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign bus.busy = busy_q;

endmodule
